// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between the fetch port and the data port.
// mem_en one cycle after grant, done LATENCY cycles later; the waiting port stalls (req & ~done).
module mem_port_arbiter #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_err,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;
    typedef enum logic {PORT_IF, PORT_DM} port_t;

    state_t              r_state;
    state_t              w_state_nxt;
    port_t               r_grant;
    port_t               r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                w_grant_vld;
    logic                w_pick_dm;
    logic                w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_vld = 1'b0;
        w_pick_dm   = 1'b0;
        w_misalign  = 1'b0;
        mem_en      = 1'b0;
        if_done     = 1'b0;
        if_rdata    = '0;
        dm_done     = 1'b0;
        dm_err      = 1'b0;
        dm_rdata    = '0;
        case (r_state)
            IDLE: begin
                if (if_req || dm_req) begin
                    w_grant_vld = 1'b1;
                    // Data port wins a tie only when fetch had the previous grant
                    w_pick_dm   = dm_req && (!if_req || r_last_grant == PORT_IF);
                    w_misalign  = w_pick_dm && dm_addr[0];
                    w_state_nxt = w_misalign ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                mem_en      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    if (r_grant == PORT_DM) begin
                        dm_done  = 1'b1;
                        dm_rdata = mem_rdata;
                    end else begin
                        if_done  = 1'b1;
                        if_rdata = mem_rdata;
                    end
                end
            end
            ERR: begin
                dm_done     = 1'b1;
                dm_err      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= PORT_IF;
            r_last_grant <= PORT_IF;
            r_cnt        <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            if (r_state == ISSUE) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNT_LAST;
            end
            if (w_grant_vld) begin
                r_grant      <= w_pick_dm ? PORT_DM : PORT_IF;
                r_last_grant <= w_pick_dm ? PORT_DM : PORT_IF;
                // A rejected misaligned access leaves the memory-side registers untouched
                if (!w_misalign) begin
                    r_mem_addr <= w_pick_dm ? dm_addr : if_addr;
                    r_mem_wr   <= w_pick_dm & dm_wr;
                    if (w_pick_dm) begin
                        r_mem_wdata <= dm_wdata;
                    end
                end
            end
        end
    end

    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_stall  = if_req & ~if_done;
    assign dm_stall  = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory accesses and completions are queued
// when a request is driven, then matched in order against what the monitor records.
module tb_mem_port_arbiter;
    localparam int          LAT = 4;
    localparam logic [31:0] L   = 32'(LAT);
    localparam logic [1:0]  K_ACC = 2'd0, K_IF = 2'd1, K_DM = 2'd2, K_VIOL = 2'd3;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_wr;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_done, if_stall, dm_done, dm_err, dm_stall, mem_en, mem_wr;

    mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_done(dm_done), .dm_err(dm_err), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_idx   = 0;
    ev_t         obs_q[$];
    ev_t         exp_q[$];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_wdata;

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic ev_t mk(input logic [31:0] c, input logic [1:0] k, input logic [15:0] a,
                               input logic w, input logic [15:0] wd, input logic [15:0] rd, input logic er);
        ev_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.wr = w; e.wdata = wd; e.rdata = rd; e.err = er;
        return e;
    endfunction

    function automatic string fmt(input ev_t e);
        return $sformatf("{cyc=%0d kind=%0d addr=%h wr=%0d wdata=%h rdata=%h err=%0d}",
                         e.cyc, e.kind, e.addr, e.wr, e.wdata, e.rdata, e.err);
    endfunction

    // Memory macro model: fixed latency, returns the addressed word (the new word for writes)
    logic [15:0] ram [logic [15:0]];
    logic [31:0] due_q[$];
    logic [15:0] dadr_q[$];
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && mem_en === 1'b1) begin
            if (mem_wr === 1'b1) ram[mem_addr] = mem_wdata;
            due_q.push_back(cyc + L);
            dadr_q.push_back(mem_addr);
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_rdata = ram.exists(dadr_q[0]) ? ram[dadr_q[0]] : dflt(dadr_q[0]);
            void'(due_q.pop_front());
            void'(dadr_q.pop_front());
        end else begin
            mem_rdata = 16'hDEAD;
        end
    end

    // Monitor: records accesses, completions and any protocol-invariant breach
    always @(negedge clk) begin
        ev_t o;
        if (mem_en === 1'b1) begin
            o = mk(cyc, K_ACC, mem_addr, mem_wr, mem_wdata, 16'h0, 1'b0);
            obs_q.push_back(o);
        end
        if (if_done === 1'b1) begin
            o = mk(cyc, K_IF, 16'h0, 1'b0, 16'h0, if_rdata, 1'b0);
            obs_q.push_back(o);
        end
        if (dm_done === 1'b1) begin
            o = mk(cyc, K_DM, 16'h0, 1'b0, 16'h0, dm_rdata, dm_err);
            obs_q.push_back(o);
        end
        if ((if_done !== 1'b1 && if_rdata !== 16'h0) || (dm_done !== 1'b1 && (dm_rdata !== 16'h0 || dm_err !== 1'b0)) ||
            (if_done === 1'b1 && dm_done === 1'b1) ||
            if_stall !== (if_req & ~if_done) || dm_stall !== (dm_req & ~dm_done)) begin
            o = mk(cyc, K_VIOL, if_rdata, if_stall, dm_rdata, {12'h0, if_done, dm_done, dm_stall, dm_err}, 1'b1);
            obs_q.push_back(o);
        end
    end

    task automatic test_reset();
        logic [31:0] c0;
        ev_t e, o;
        rst_n = 1'b0; if_req = 1'b1; if_addr = 16'h0030;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200; dm_wdata = 16'h5555;
        last_wdata = 16'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata, dm_done, dm_err, dm_rdata} !== 68'h0) begin
                n_fail++;
                $display("FAIL reset outputs: got en=%0d wr=%0d addr=%h wdata=%h ifd=%0d ifr=%h dmd=%0d err=%0d dmr=%h, want all 0",
                         mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata, dm_done, dm_err, dm_rdata);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset activity: got %0d events during reset, want 0", obs_q.size());
        end
        rst_n = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(c0 + 32'd1, K_ACC, 16'h0200, 1'b0, 16'h5555, 16'h0, 1'b0));
        last_wdata = 16'h5555;
        exp_q.push_back(mk(c0 + 32'd1 + L, K_DM, 16'h0, 1'b0, 16'h0, ref_rd(16'h0200), 1'b0));
        exp_q.push_back(mk(c0 + 32'd3 + L, K_ACC, 16'h0030, 1'b0, last_wdata, 16'h0, 1'b0));
        exp_q.push_back(mk(c0 + 32'd3 + 2 * L, K_IF, 16'h0, 1'b0, 16'h0, ref_rd(16'h0030), 1'b0));
        for (int k = 0; k < 40 && (if_req || dm_req); k++) begin
            @(negedge clk); #1;
            if (if_done) if_req = 1'b0;
            if (dm_done) dm_req = 1'b0;
        end
        n_checks++;
        if (if_req || dm_req) begin
            n_fail++;
            $display("FAIL reset timeout: reqs still pending if=%0d dm=%0d, want both completed", if_req, dm_req);
            if_req = 1'b0; dm_req = 1'b0;
        end
        while (exp_q.size() > 0 || rd_idx < obs_q.size()) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin o = obs_q[rd_idx]; rd_idx++; end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset event: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_fetch();
        logic [31:0] c0;
        ev_t e, o;
        @(negedge clk); #1;
        c0 = cyc;
        if_req = 1'b1; if_addr = 16'h0010;
        exp_q.push_back(mk(c0 + 32'd1, K_ACC, 16'h0010, 1'b0, last_wdata, 16'h0, 1'b0));
        exp_q.push_back(mk(c0 + 32'd1 + L, K_IF, 16'h0, 1'b0, 16'h0, 16'hBEEF, 1'b0));
        for (int k = 0; k < 40 && if_req; k++) begin
            @(negedge clk); #1;
            if (if_done) if_req = 1'b0;
        end
        n_checks++;
        if (if_req) begin n_fail++; $display("FAIL fetch timeout: got if_req still pending, want if_done"); if_req = 1'b0; end
        while (exp_q.size() > 0 || rd_idx < obs_q.size()) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin o = obs_q[rd_idx]; rd_idx++; end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL fetch event: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_store();
        logic [31:0] c0;
        ev_t e, o;
        @(negedge clk); #1;
        c0 = cyc;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
        exp_q.push_back(mk(c0 + 32'd1, K_ACC, 16'h0100, 1'b1, 16'h1234, 16'h0, 1'b0));
        ref_mem[16'h0100] = 16'h1234;
        last_wdata = 16'h1234;
        exp_q.push_back(mk(c0 + 32'd1 + L, K_DM, 16'h0, 1'b0, 16'h0, 16'h1234, 1'b0));
        for (int k = 0; k < 40 && dm_req; k++) begin
            @(negedge clk); #1;
            if (dm_done) dm_req = 1'b0;
        end
        n_checks++;
        if (dm_req) begin n_fail++; $display("FAIL store timeout: got dm_req still pending, want dm_done"); dm_req = 1'b0; end
        while (exp_q.size() > 0 || rd_idx < obs_q.size()) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin o = obs_q[rd_idx]; rd_idx++; end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL store event: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c0;
        int          dones;
        ev_t e, o;
        @(negedge clk); #1;
        c0 = cyc;
        dones = 0;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0102; dm_wdata = 16'hCAFE;
        exp_q.push_back(mk(c0 + 32'd1, K_ACC, 16'h0102, 1'b1, 16'hCAFE, 16'h0, 1'b0));
        ref_mem[16'h0102] = 16'hCAFE;
        exp_q.push_back(mk(c0 + 32'd1 + L, K_DM, 16'h0, 1'b0, 16'h0, 16'hCAFE, 1'b0));
        exp_q.push_back(mk(c0 + 32'd3 + L, K_ACC, 16'h0102, 1'b0, 16'h0F0F, 16'h0, 1'b0));
        last_wdata = 16'h0F0F;
        exp_q.push_back(mk(c0 + 32'd3 + 2 * L, K_DM, 16'h0, 1'b0, 16'h0, ref_rd(16'h0102), 1'b0));
        for (int k = 0; k < 40 && dm_req; k++) begin
            @(negedge clk); #1;
            if (dm_done) begin
                dones++;
                if (dones == 1) begin dm_wr = 1'b0; dm_wdata = 16'h0F0F; end
                else dm_req = 1'b0;
            end
        end
        n_checks++;
        if (dm_req) begin n_fail++; $display("FAIL back_to_back timeout: got %0d dm_done, want 2", dones); dm_req = 1'b0; end
        while (exp_q.size() > 0 || rd_idx < obs_q.size()) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin o = obs_q[rd_idx]; rd_idx++; end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL back_to_back event: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] c0;
        ev_t e, o;
        @(negedge clk); #1;
        c0 = cyc;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0101; dm_wdata = last_wdata;
        exp_q.push_back(mk(c0 + 32'd1, K_DM, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1));
        exp_q.push_back(mk(c0 + 32'd3, K_ACC, 16'h0022, 1'b0, last_wdata, 16'h0, 1'b0));
        exp_q.push_back(mk(c0 + 32'd3 + L, K_IF, 16'h0, 1'b0, 16'h0, ref_rd(16'h0022), 1'b0));
        for (int k = 0; k < 40 && (k == 0 || if_req || dm_req); k++) begin
            @(negedge clk); #1;
            if (if_done) if_req = 1'b0;
            if (dm_done) dm_req = 1'b0;
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0022; end
        end
        n_checks++;
        if (if_req || dm_req) begin
            n_fail++;
            $display("FAIL misaligned timeout: reqs still pending if=%0d dm=%0d, want both completed", if_req, dm_req);
            if_req = 1'b0; dm_req = 1'b0;
        end
        while (exp_q.size() > 0 || rd_idx < obs_q.size()) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin o = obs_q[rd_idx]; rd_idx++; end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL misaligned event: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_contention();
        logic [31:0] c0;
        logic [31:0] g;
        logic [15:0] a;
        ev_t e, o;
        @(negedge clk); #1;
        c0 = cyc;
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0400; dm_wdata = 16'h7777;
        last_wdata = 16'h7777;
        // Addresses move every cycle, so each grant must capture the value present at its own grant cycle
        for (int j = 0; j < 4; j++) begin
            g = 32'(6 * j);
            if (j % 2 == 0) begin
                a = 16'h0400 + 16'(2 * g);
                exp_q.push_back(mk(c0 + g + 32'd1, K_ACC, a, 1'b0, 16'h7777, 16'h0, 1'b0));
                exp_q.push_back(mk(c0 + g + 32'd1 + L, K_DM, 16'h0, 1'b0, 16'h0, ref_rd(a), 1'b0));
            end else begin
                a = 16'h0040 + 16'(2 * g);
                exp_q.push_back(mk(c0 + g + 32'd1, K_ACC, a, 1'b0, 16'h7777, 16'h0, 1'b0));
                exp_q.push_back(mk(c0 + g + 32'd1 + L, K_IF, 16'h0, 1'b0, 16'h0, ref_rd(a), 1'b0));
            end
        end
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk); #1;
            if_addr = 16'h0040 + 16'(2 * k);
            dm_addr = 16'h0400 + 16'(2 * k);
        end
        if_req = 1'b0; dm_req = 1'b0;
        while (exp_q.size() > 0 || rd_idx < obs_q.size()) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin o = obs_q[rd_idx]; rd_idx++; end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL contention event: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] c0, cr;
        ev_t e, o;
        @(negedge clk); #1;
        c0 = cyc;
        if_req = 1'b1; if_addr = 16'h0044;
        exp_q.push_back(mk(c0 + 32'd1, K_ACC, 16'h0044, 1'b0, last_wdata, 16'h0, 1'b0));
        repeat (3) begin @(negedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata, dm_done, dm_err, dm_rdata} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_mid_wait outputs: got en=%0d wr=%0d addr=%h wdata=%h ifd=%0d ifr=%h dmd=%0d, want all 0",
                     mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata, dm_done);
        end
        repeat (2) begin @(negedge clk); #1; end
        rst_n = 1'b1;
        cr = cyc;
        last_wdata = 16'h0;
        exp_q.push_back(mk(cr + 32'd1, K_ACC, 16'h0044, 1'b0, 16'h0, 16'h0, 1'b0));
        exp_q.push_back(mk(cr + 32'd1 + L, K_IF, 16'h0, 1'b0, 16'h0, ref_rd(16'h0044), 1'b0));
        for (int k = 0; k < 40 && if_req; k++) begin
            @(negedge clk); #1;
            if (if_done) if_req = 1'b0;
        end
        n_checks++;
        if (if_req) begin n_fail++; $display("FAIL reset_mid_wait timeout: got if_req still pending, want if_done"); if_req = 1'b0; end
        while (exp_q.size() > 0 || rd_idx < obs_q.size()) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin o = obs_q[rd_idx]; rd_idx++; end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_mid_wait event: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_misaligned();
        test_contention();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want test sequence complete");
        $fatal(1, "watchdog expired");
    end

endmodule
